// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing for the bit-serial subtractor.
// FSM encodings, width limits and counter sizing.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle.
// master drives requests, slave is the subtractor.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, x, y,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, x, y,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell, port order of full_adder.
// d = a - b - bin, bout is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Single full_subtractor cell, shift registers, start/busy/done FSM.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           next;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bflop;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;
  logic             last;
  logic             capture;
  logic [WIDTH-1:0] rs_next;

  full_subtractor u_fs (
    .a   (xs[0]),
    .b   (ys[0]),
    .bin (bflop),
    .d   (d),
    .bout(bout)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign rs_next = {d, rs[WIDTH-1:1]};
  assign capture = bus.start &&
                   (state == S_IDLE || state == S_DONE);

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: if (bus.start) next = S_RUN;
      S_RUN:  if (last) next = S_DONE;
      S_DONE: next = bus.start ? S_RUN : S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  // diff/borrow only move on the completing edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      xs       <= '0;
      ys       <= '0;
      rs       <= '0;
      bflop    <= 1'b0;
      cnt      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state <= next;
      if (capture) begin
        xs    <= bus.x;
        ys    <= bus.y;
        rs    <= '0;
        bflop <= 1'b0;
        cnt   <= '0;
      end else if (state == S_RUN) begin
        xs    <= xs >> 1;
        ys    <= ys >> 1;
        rs    <= rs_next;
        bflop <= bout;
        cnt   <= cnt + CW'(1);
        if (last) begin
          diff_q   <= rs_next;
          borrow_q <= bout;
        end
      end
    end
  end

  assign bus.busy   = (state == S_RUN);
  assign bus.done   = (state == S_DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized bench for serial_subtractor (WIDTH 8 and 2 builds).
// Cycle-level arithmetic model plus literal spot checks.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) b8 ();
  serial_subtractor_if #(.WIDTH(2)) b2 ();

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (b8.slave)
  );

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (b2.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: remaining busy cycles, done flag, held result
  int          m_left [2];
  logic        m_done [2];
  logic [31:0] m_diff [2];
  logic        m_bor  [2];
  logic [31:0] m_x    [2];
  logic [31:0] m_y    [2];

  task automatic step(int i, logic st, logic [31:0] x, logic [31:0] y);
    int          w;
    logic [31:0] mask;
    logic [32:0] r;
    w    = (i == 1) ? 2 : 8;
    mask = (32'd1 << w) - 32'd1;
    if (reset) begin
      m_left[i] = 0;
      m_done[i] = 1'b0;
      m_diff[i] = '0;
      m_bor[i]  = 1'b0;
    end else if (m_left[i] > 0) begin
      m_left[i]--;
      m_done[i] = 1'b0;
      if (m_left[i] == 0) begin
        r = {1'b0, m_x[i]} - {1'b0, m_y[i]};
        m_done[i] = 1'b1;
        m_diff[i] = r[31:0] & mask;
        m_bor[i]  = r[32];
      end
    end else begin
      m_done[i] = 1'b0;
      if (st) begin
        m_left[i] = w;
        m_x[i]    = x & mask;
        m_y[i]    = y & mask;
      end
    end
  endtask

  always @(posedge clk) begin
    step(0, b8.start, 32'(b8.x), 32'(b8.y));
    step(1, b2.start, 32'(b2.x), 32'(b2.y));
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_w8",
            64'({b8.busy, b8.done, b8.borrow, b8.diff}),
            64'({m_left[0] > 0, m_done[0], m_bor[0], m_diff[0][7:0]}));
      check("cyc_w2",
            64'({b2.busy, b2.done, b2.borrow, b2.diff}),
            64'({m_left[1] > 0, m_done[1], m_bor[1], m_diff[1][1:0]}));
    end
  end

  task automatic start8(logic [7:0] x, logic [7:0] y);
    @(negedge clk);
    b8.start = 1'b1;
    b8.x     = x;
    b8.y     = y;
    @(negedge clk);
    b8.start = 1'b0;
    b8.x     = 8'($urandom);
    b8.y     = 8'($urandom);
  endtask

  task automatic start2(logic [1:0] x, logic [1:0] y);
    @(negedge clk);
    b2.start = 1'b1;
    b2.x     = x;
    b2.y     = y;
    @(negedge clk);
    b2.start = 1'b0;
  endtask

  // returns negedges waited until done seen (bounded)
  task automatic wait_done(int i, int budget, output int cyc);
    cyc = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      cyc++;
      if ((i == 1) ? b2.done : b8.done) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL timeout_%0d: no done after %0d cycles, expected one", i, cyc);
  endtask

  task automatic op8(logic [7:0] x, logic [7:0] y, string nm);
    int c;
    logic [8:0] e;
    e = {1'b0, x} - {1'b0, y};
    start8(x, y);
    wait_done(0, 40, c);
    check(nm, 64'({b8.borrow, b8.diff}), 64'(e));
  endtask

  initial begin
    int c;
    int nb;
    int ndone;
    reset    = 1'b1;
    b8.start = 1'b0;
    b8.x     = '0;
    b8.y     = '0;
    b2.start = 1'b0;
    b2.x     = '0;
    b2.y     = '0;
    repeat (2) @(negedge clk);
    started = 1;
    check("reset_state",
          64'({b8.busy, b8.done, b8.borrow, b8.diff}), 64'd0);
    reset = 1'b0;

    // case 1: 200 - 55, busy exactly 8 cycles
    start8(8'd200, 8'd55);
    nb = b8.busy ? 1 : 0;
    c  = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      c++;
      if (b8.done) break;
      if (b8.busy) nb++;
    end
    check("c1_latency", 64'(c), 64'd8);
    check("c1_busy_cycles", 64'(nb), 64'd8);
    check("c1_diff", 64'(b8.diff), 64'd145);
    check("c1_borrow", 64'(b8.borrow), 64'd0);

    // case 6: result held while idle, no done
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (b8.done) ndone++;
    end
    check("c6_no_done", 64'(ndone), 64'd0);
    check("c6_hold", 64'({b8.borrow, b8.diff}), 64'd145);

    // case 2: literal pins
    start8(8'd5, 8'd10);
    wait_done(0, 40, c);
    check("c2_5m10", 64'({b8.borrow, b8.diff}), 64'h1FB);
    start8(8'd0, 8'd0);
    wait_done(0, 40, c);
    check("c2_0m0", 64'({b8.borrow, b8.diff}), 64'h000);
    start8(8'd255, 8'd255);
    wait_done(0, 40, c);
    check("c2_255m255", 64'({b8.borrow, b8.diff}), 64'h000);

    // case 3: start held high, new operands each DONE, junk mid-run
    @(negedge clk);
    b8.start = 1'b1;
    b8.x     = 8'($urandom);
    b8.y     = 8'($urandom);
    ndone    = 0;
    for (int op = 0; op < 6; op++) begin
      c = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        c++;
        if (b8.done) break;
        if (c < 6) begin
          b8.start = 1'($urandom);
          b8.x     = 8'($urandom);
          b8.y     = 8'($urandom);
        end else begin
          b8.start = 1'b1;
        end
      end
      if (b8.done) ndone++;
      check("c3_period", 64'(c), 64'd9);
      b8.start = (op < 5);
      b8.x     = 8'($urandom);
      b8.y     = 8'($urandom);
    end
    check("c3_done_count", 64'(ndone), 64'd6);
    repeat (3) @(negedge clk);

    // case 4: reset at cnt=4 aborts silently
    start8(8'd100, 8'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("c4_cleared",
          64'({b8.busy, b8.done, b8.borrow, b8.diff}), 64'd0);
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (b8.done) ndone++;
    end
    check("c4_no_done", 64'(ndone), 64'd0);
    op8(8'd77, 8'd30, "c4_after");

    // random ops with random gaps
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      op8(8'($urandom), 8'($urandom), "rand_w8");
    end

    // case 5: WIDTH=2 exhaustive
    for (int xi = 0; xi < 4; xi++) begin
      for (int yi = 0; yi < 4; yi++) begin
        logic [2:0] e;
        e = {1'b0, 2'(xi)} - {1'b0, 2'(yi)};
        start2(2'(xi), 2'(yi));
        wait_done(1, 10, c);
        check("c5_w2", 64'({b2.borrow, b2.diff}), 64'(e));
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
